// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID register, RUN/HALT FSM, one-cycle PC-to-IF/ID latency.
// Optional FETCH_MISALIGN_TRAP_EN traps on misaligned redirect targets; otherwise target bits[1:0] are cleared.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 18
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_inst,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_inst,
  output logic        done,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
  localparam logic [1:0]  RUN        = 2'd0;
  localparam logic [1:0]  HALT       = 2'd1;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [1:0]  TRAP       = 2'd2;
`endif

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  state;
  logic [31:0] tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic tgt_bad;
  assign tgt     = redirect_target;
  assign tgt_bad = |redirect_target[1:0];
`else
  logic unused_tgt_lsb;
  assign tgt            = {redirect_target[31:2], 2'b00};
  assign unused_tgt_lsb = ^redirect_target[1:0];
`endif

  assign pc_plus4 = pc + 32'd4;
  assign imem_pc  = pc;
  assign done     = (state != RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      state         <= RUN;
      ifid_valid    <= 1'b0;
      ifid_pc       <= 32'h0;
      ifid_pc_plus4 <= 32'h0;
      ifid_inst     <= NOP;
      fetch_count   <= 32'h0;
    end else begin
      case (state)
        RUN: begin
          if (redirect_valid) begin
            ifid_valid <= 1'b0;
            ifid_inst  <= NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (tgt_bad) state <= TRAP;
            else
`endif
            pc <= tgt;
          end else if (stall) begin
            if (flush) begin
              ifid_valid <= 1'b0;
              ifid_inst  <= NOP;
            end
          end else if (pc >= IMEM_BYTES) begin
            ifid_valid <= 1'b0;
            ifid_inst  <= NOP;
            state      <= HALT;
          end else if (flush) begin
            ifid_valid <= 1'b0;
            ifid_inst  <= NOP;
            pc         <= pc_plus4;
          end else begin
            ifid_valid    <= 1'b1;
            ifid_pc       <= pc;
            ifid_pc_plus4 <= pc_plus4;
            ifid_inst     <= imem_inst;
            pc            <= pc_plus4;
            fetch_count   <= fetch_count + 32'd1;
          end
        end
        HALT: begin
          ifid_valid <= 1'b0;
          ifid_inst  <= NOP;
          if (redirect_valid) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (tgt_bad) state <= TRAP;
            else
`endif
            // Out-of-range targets are ignored; only reset or a valid target restarts fetch.
            if (tgt < IMEM_BYTES) begin
              pc    <= tgt;
              state <= RUN;
            end
          end
        end
        default: begin
          ifid_valid <= 1'b0;
          ifid_inst  <= NOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction-memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, redirect_valid;
  logic [31:0] redirect_target, imem_pc, imem_inst;
  logic        ifid_valid, done;
  logic [31:0] ifid_pc, ifid_pc_plus4, ifid_inst, fetch_count;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(18)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_pc(imem_pc), .imem_inst(imem_inst),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_inst(ifid_inst), .done(done), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;
  assign imem_inst = imem_pc ^ 32'hDEAD_0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic f, input logic rv, input logic [31:0] t);
    rst_n = r; stall = s; flush = f; redirect_valid = rv; redirect_target = t;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("rst_pc", imem_pc, 32'h0);
    chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
    chk("rst_inst", ifid_inst, 32'h13);
    chk("rst_ifid_pc", ifid_pc, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);

    // Sequential fetch from RESET_PC
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("seq0_pc", ifid_pc, 32'h0);
    chk("seq0_pc4", ifid_pc_plus4, 32'h4);
    chk("seq0_inst", ifid_inst, 32'hDEAD_0000);
    chk("seq0_valid", {31'h0, ifid_valid}, 32'h1);
    step();
    chk("seq1_pc", ifid_pc, 32'h4);
    step();
    chk("seq2_pc", ifid_pc, 32'h8);
    chk("seq_count", fetch_count, 32'd3);
    chk("seq_imem_pc", imem_pc, 32'hC);

    // Redirect to 8, then redirect with stall to 0x20
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h8);
    step();
    chk("redir_pc", imem_pc, 32'h8);
    chk("redir_count", fetch_count, 32'd3);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h20);
    step();
    chk("redir_stall_pc", imem_pc, 32'h20);
    chk("redir_stall_valid", {31'h0, ifid_valid}, 32'h0);
    chk("redir_stall_inst", ifid_inst, 32'h13);

    // Stall, then stall+flush at PC=0x10
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'hC);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("pre_stall_ifid", ifid_pc, 32'hC);
    chk("pre_stall_count", fetch_count, 32'd4);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk("stall_pc", imem_pc, 32'h10);
    chk("stall_valid", {31'h0, ifid_valid}, 32'h1);
    chk("stall_count", fetch_count, 32'd4);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    step();
    chk("stflush_pc", imem_pc, 32'h10);
    chk("stflush_valid", {31'h0, ifid_valid}, 32'h0);
    chk("stflush_count", fetch_count, 32'd4);

    // Flush alone advances PC but not the count
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    step();
    chk("flush_pc", imem_pc, 32'h14);
    chk("flush_valid", {31'h0, ifid_valid}, 32'h0);
    chk("flush_inst", ifid_inst, 32'h13);
    chk("flush_count", fetch_count, 32'd4);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("post_flush_ifid", ifid_pc, 32'h14);
    chk("post_flush_count", fetch_count, 32'd5);

    // Run off the end of memory (last valid PC is 0x44)
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h44);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("last_ifid", ifid_pc, 32'h44);
    chk("last_done", {31'h0, done}, 32'h0);
    step();
    chk("halt_done", {31'h0, done}, 32'h1);
    chk("halt_pc", imem_pc, 32'h48);
    chk("halt_valid", {31'h0, ifid_valid}, 32'h0);
    chk("halt_count", fetch_count, 32'd6);
    step();
    chk("halt_hold_pc", imem_pc, 32'h48);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
    step();
    chk("halt_oor_done", {31'h0, done}, 32'h1);
    chk("halt_oor_pc", imem_pc, 32'h48);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h4);
    step();
    chk("unhalt_done", {31'h0, done}, 32'h0);
    chk("unhalt_pc", imem_pc, 32'h4);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("unhalt_ifid", ifid_pc, 32'h4);
    chk("unhalt_valid", {31'h0, ifid_valid}, 32'h1);
    chk("unhalt_count", fetch_count, 32'd7);

    // Misaligned redirect target
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h22);
    step();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("trap_done", {31'h0, done}, 32'h1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h4);
    step();
    chk("trap_sticky", {31'h0, done}, 32'h1);
    chk("trap_valid", {31'h0, ifid_valid}, 32'h0);
`else
    chk("misalign_pc", imem_pc, 32'h20);
    chk("misalign_done", {31'h0, done}, 32'h0);
`endif

    // Reset while stalled at PC=0x30
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h2C);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("pre_rst_pc", imem_pc, 32'h30);
    chk("pre_rst_count", fetch_count, 32'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h40);
    step();
    chk("rst_stall_pc", imem_pc, 32'h0);
    chk("rst_stall_count", fetch_count, 32'd0);
    chk("rst_stall_valid", {31'h0, ifid_valid}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("post_rst_ifid", ifid_pc, 32'h0);
    chk("post_rst_valid", {31'h0, ifid_valid}, 32'h1);
    chk("post_rst_count", fetch_count, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
